cam_ctrl: RTL and testbench
===========================

Name: cam_ctrl

Overview:
- Request front-end that sits directly upstream of the cam block and drives its read, write and search ports.
- Accepts LOOKUP / INSERT / READ / FLUSH requests over a valid/ready handshake and sequences the CAM accesses for each one.
- Tracks occupancy with a sequential fill counter and returns one response per request over a valid/ready handshake.

Parameters:
- WIDTH, 32, key/data width; equals the cam WIDTH.
- ADDR_WIDTH, 5, entry index width.
- HEIGHT, 32, number of CAM entries; must equal 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  2  cam_pkg::op_e: LOOKUP=0, INSERT=1, READ=2, FLUSH=3.
- req_key_i  in  WIDTH  key for LOOKUP/INSERT.
- req_index_i  in  ADDR_WIDTH  entry index for READ.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_status_o  out  2  cam_pkg::status_e: HIT=0, MISS=1, INSERTED=2, FULL=3.
- rsp_index_o  out  ADDR_WIDTH  matched, written or read index.
- rsp_data_o  out  WIDTH  READ data; 0 for all other ops.
- cam_read_enable_o  out  1  CAM read enable.
- cam_read_index_o  out  ADDR_WIDTH  CAM read index.
- cam_write_enable_o  out  1  CAM write enable.
- cam_write_index_o  out  ADDR_WIDTH  CAM write index.
- cam_write_data_o  out  WIDTH  CAM write data.
- cam_search_enable_o  out  1  CAM search enable.
- cam_search_data_o  out  WIDTH  CAM search key.
- cam_read_valid_i  in  1  CAM read data valid.
- cam_read_value_i  in  WIDTH  CAM read data.
- cam_search_valid_i  in  1  CAM match found.
- cam_search_index_i  in  ADDR_WIDTH  lowest matching index.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, count=0.
  - All outputs 0 except req_ready_o, which goes to 1 in the first cycle after rst_i deasserts.
  - Asserting rst_i mid-operation aborts the request: no response is issued, and any pending rsp_valid_o is dropped.
- Occupancy model:
  - count is ADDR_WIDTH+1 bits, range 0..HEIGHT.
  - Entries 0..count-1 are valid and are filled strictly in order; the block never deletes individual entries.
  - The CAM priority encoder returns the lowest matching index, so a match is a hit iff cam_search_valid_i=1 and cam_search_index_i < count. Any match at or above count is stale data and is treated as a miss.
- Handshakes:
  - req_ready_o=1 only in IDLE. A request is accepted when req_valid_i && req_ready_o; op, key and index are registered at that edge.
  - rsp_* outputs are stable while rsp_valid_o=1 and rsp_ready_i=0. The response completes on rsp_valid_o && rsp_ready_i, and the FSM returns to IDLE.
  - The CAM enable outputs are single-cycle pulses and are never asserted outside their own state.
- FSM states: IDLE, SRCH, EVAL, WRITE, RD, RESP.
  - IDLE -> SRCH for LOOKUP/INSERT; IDLE -> RD for READ; IDLE -> RESP for FLUSH.
  - SRCH: cam_search_enable_o=1 and cam_search_data_o=key. Always go to EVAL.
  - EVAL: sample cam_search_valid_i and cam_search_index_i.
    - Hit -> RESP, status HIT, index = matching index (both LOOKUP and INSERT).
    - LOOKUP miss -> RESP, status MISS, index 0.
    - INSERT miss with count<HEIGHT -> WRITE.
    - INSERT miss with count==HEIGHT -> RESP, status FULL, index 0.
  - WRITE: cam_write_enable_o=1, write index = count[ADDR_WIDTH-1:0], write data = key. count increments. Go to RESP with status INSERTED, index = old count.
  - RD:
    - If req_index >= count -> RESP, status MISS, data 0, and no CAM read is issued.
    - Otherwise pulse cam_read_enable_o for 1 cycle, then wait with no timeout for cam_read_valid_i. On valid -> RESP, status HIT, data = cam_read_value_i, index = req_index.
  - FLUSH: count <- 0 on acceptance. Response status INSERTED, index 0. CAM contents are not cleared.
- Latency from the acceptance edge T, with rsp_ready_i held high:
  - LOOKUP, and INSERT on hit: rsp_valid_o rises at T+3.
  - INSERT miss: rsp_valid_o rises at T+4.
  - FLUSH: rsp_valid_o rises at T+1.
  - READ: T+1 + CAM read latency + 1.
- Count saturates at HEIGHT and never wraps.

Decomposition:
- cam_pkg holds the op_e and status_e enums and the state_e typedef.
- No sub-module: the FSM, count register and response registers are inline, roughly 200 lines.

Test Plan:
- Reset, then INSERT key 0xDEADBEEF -> CAM write at index 0; response INSERTED, index 0, at T+4; count=1.
- LOOKUP 0xDEADBEEF -> search pulse at T+1; response HIT, index 0, at T+3. LOOKUP 0x12345678 -> MISS.
- INSERT 0xDEADBEEF again -> HIT, index 0, with no write pulse. Then 32 distinct INSERTs from empty fill indices 0..31; the 33rd INSERT -> FULL, with no write.
- After FLUSH (response at T+1), LOOKUP 0xDEADBEEF with the CAM still returning match index 0 -> MISS (stale entry masked). READ index 3 -> MISS, with no read pulse.
- READ index 1 after two inserts (0xA, 0xB) -> cam_read_enable_o pulse, then HIT with data 0xB. Hold rsp_ready_i low for 5 cycles -> response stable and req_ready_o=0 throughout.
- Assert rst_i during WRITE of an INSERT -> next cycle IDLE, count=0, rsp_valid_o=0, and no response is ever issued for the aborted request.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared enums for the CAM request front-end
package cam_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_READ   = 2'd2,
        OP_FLUSH  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_HIT      = 2'd0,
        ST_MISS     = 2'd1,
        ST_INSERTED = 2'd2,
        ST_FULL     = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SRCH  = 3'd1,
        S_EVAL  = 3'd2,
        S_WRITE = 3'd3,
        S_RD    = 3'd4,
        S_RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - request sequencer and occupancy tracker in front of the cam block
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int HEIGHT     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [WIDTH-1:0]      req_key_i,
    input  logic [ADDR_WIDTH-1:0] req_index_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_status_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_read_valid_i,
    input  logic [WIDTH-1:0]      cam_read_value_i,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(HEIGHT);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    op_e                   op_q;
    logic [WIDTH-1:0]      key_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  rd_issued_q, rd_issued_d;
    status_e               status_q, status_d;
    logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;

    logic accept;
    logic search_hit;
    logic read_in_range;

    assign accept        = req_valid_i && req_ready_o;
    // Matches at or above the fill level are leftovers from before a flush.
    assign search_hit    = cam_search_valid_i && ({1'b0, cam_search_index_i} < count_q);
    assign read_in_range = {1'b0, index_q} < count_q;

    assign req_ready_o         = (state_q == S_IDLE) && !rst_i;
    assign rsp_valid_o         = (state_q == S_RESP);
    assign rsp_status_o        = status_q;
    assign rsp_index_o         = rsp_index_q;
    assign rsp_data_o          = rsp_data_q;
    assign cam_search_enable_o = (state_q == S_SRCH);
    assign cam_search_data_o   = key_q;
    assign cam_write_enable_o  = (state_q == S_WRITE);
    assign cam_write_index_o   = count_q[ADDR_WIDTH-1:0];
    assign cam_write_data_o    = key_q;
    assign cam_read_enable_o   = (state_q == S_RD) && read_in_range && !rd_issued_q;
    assign cam_read_index_o    = index_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            op_q        <= OP_LOOKUP;
            key_q       <= '0;
            index_q     <= '0;
            rd_issued_q <= 1'b0;
            status_q    <= ST_HIT;
            rsp_index_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_issued_q <= rd_issued_d;
            status_q    <= status_d;
            rsp_index_q <= rsp_index_d;
            rsp_data_q  <= rsp_data_d;
            if (accept) begin
                op_q    <= op_e'(req_op_i);
                key_q   <= req_key_i;
                index_q <= req_index_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_issued_d = rd_issued_q;
        status_d    = status_q;
        rsp_index_d = rsp_index_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_e'(req_op_i))
                        OP_LOOKUP, OP_INSERT: state_d = S_SRCH;
                        OP_READ:              state_d = S_RD;
                        default: begin
                            count_d     = '0;
                            status_d    = ST_INSERTED;
                            rsp_index_d = '0;
                            rsp_data_d  = '0;
                            state_d     = S_RESP;
                        end
                    endcase
                end
            end
            S_SRCH: state_d = S_EVAL;
            S_EVAL: begin
                rsp_data_d  = '0;
                rsp_index_d = '0;
                state_d     = S_RESP;
                if (search_hit) begin
                    status_d    = ST_HIT;
                    rsp_index_d = cam_search_index_i;
                end else if (op_q == OP_LOOKUP) begin
                    status_d = ST_MISS;
                end else if (count_q < FULL_COUNT) begin
                    state_d = S_WRITE;
                end else begin
                    status_d = ST_FULL;
                end
            end
            S_WRITE: begin
                count_d     = count_q + 1'b1;
                status_d    = ST_INSERTED;
                rsp_index_d = count_q[ADDR_WIDTH-1:0];
                rsp_data_d  = '0;
                state_d     = S_RESP;
            end
            S_RD: begin
                // The read is issued once, then the wait for data is unbounded.
                if (!read_in_range) begin
                    status_d    = ST_MISS;
                    rsp_index_d = '0;
                    rsp_data_d  = '0;
                    state_d     = S_RESP;
                end else if (!rd_issued_q) begin
                    rd_issued_d = 1'b1;
                end else if (cam_read_valid_i) begin
                    rd_issued_d = 1'b0;
                    status_d    = ST_HIT;
                    rsp_index_d = index_q;
                    rsp_data_d  = cam_read_value_i;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - randomized self-checking bench for cam_ctrl with a behavioural CAM
module tb_cam_ctrl;
    import cam_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = 2'd0;
    logic [31:0] req_key_i = '0;
    logic [4:0]  req_index_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [1:0]  rsp_status_o;
    logic [4:0]  rsp_index_o;
    logic [31:0] rsp_data_o;
    logic        cam_read_enable_o;
    logic [4:0]  cam_read_index_o;
    logic        cam_write_enable_o;
    logic [4:0]  cam_write_index_o;
    logic [31:0] cam_write_data_o;
    logic        cam_search_enable_o;
    logic [31:0] cam_search_data_o;
    logic        cam_read_valid_i = 1'b0;
    logic [31:0] cam_read_value_i = '0;
    logic        cam_search_valid_i = 1'b0;
    logic [4:0]  cam_search_index_i = '0;

    int n_vec = 0;
    int n_err = 0;

    cam_ctrl #(.WIDTH(32), .ADDR_WIDTH(5), .HEIGHT(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_key_i(req_key_i), .req_index_i(req_index_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_status_o(rsp_status_o), .rsp_index_o(rsp_index_o), .rsp_data_o(rsp_data_o),
        .cam_read_enable_o(cam_read_enable_o), .cam_read_index_o(cam_read_index_o),
        .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
        .cam_write_data_o(cam_write_data_o),
        .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
        .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
        .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: one-cycle search, two-cycle read, contents survive flush.
    logic [31:0] cmem [32];
    logic        cwr  [32];
    logic        rd_p1;
    logic [4:0]  rd_i1;

    initial begin
        for (int i = 0; i < 32; i++) begin
            cmem[i] = '0;
            cwr[i]  = 1'b0;
        end
        rd_p1 = 1'b0;
        rd_i1 = '0;
    end

    always @(posedge clk) begin
        if (cam_write_enable_o) begin
            cmem[cam_write_index_o] <= cam_write_data_o;
            cwr[cam_write_index_o]  <= 1'b1;
        end
        if (cam_search_enable_o) begin
            cam_search_valid_i <= 1'b0;
            cam_search_index_i <= '0;
            for (int i = 31; i >= 0; i--) begin
                if (cwr[i] && cmem[i] == cam_search_data_o) begin
                    cam_search_valid_i <= 1'b1;
                    cam_search_index_i <= 5'(i);
                end
            end
        end
        rd_p1            <= cam_read_enable_o;
        rd_i1            <= cam_read_index_o;
        cam_read_valid_i <= rd_p1;
        cam_read_value_i <= cmem[rd_i1];
    end

    // Reference: list of valid keys in fill order.
    logic [31:0] ref_q [$];

    task automatic model_op(input logic [1:0] op, input logic [31:0] key, input logic [4:0] idx,
                            output logic [1:0] st, output logic [4:0] ix,
                            output logic [31:0] dt, output int lat);
        int found;
        found = -1;
        for (int i = 0; i < ref_q.size(); i++)
            if (found < 0 && ref_q[i] == key) found = i;
        st = ST_MISS; ix = '0; dt = '0; lat = 3;
        case (op)
            OP_LOOKUP: if (found >= 0) begin st = ST_HIT; ix = 5'(found); end
            OP_INSERT: begin
                if (found >= 0) begin
                    st = ST_HIT; ix = 5'(found);
                end else if (ref_q.size() == 32) begin
                    st = ST_FULL;
                end else begin
                    st = ST_INSERTED; ix = 5'(ref_q.size()); lat = 4;
                    ref_q.push_back(key);
                end
            end
            OP_READ: begin
                if (int'(idx) < ref_q.size()) begin
                    st = ST_HIT; ix = idx; dt = ref_q[idx]; lat = 4;
                end else begin
                    lat = 2;
                end
            end
            default: begin
                st = ST_INSERTED; lat = 1;
                ref_q.delete();
            end
        endcase
    endtask

    logic [1:0]  r_st;
    logic [4:0]  r_ix;
    logic [31:0] r_dt;
    int          r_lat, r_nwr, r_nsr, r_nrd, r_srch_at;
    bit          r_stable;

    // Issues one request, collects the response and the CAM pulses seen on the way.
    task automatic do_op(input logic [1:0] op, input logic [31:0] key,
                         input logic [4:0] idx, input int hold);
        int n;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_index_i = idx;
        rsp_ready_i = (hold == 0);
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        r_lat = 0; r_nwr = 0; r_nsr = 0; r_nrd = 0; r_srch_at = -1;
        forever begin
            @(negedge clk);
            req_valid_i = 1'b0;
            r_lat++;
            if (cam_write_enable_o) r_nwr++;
            if (cam_read_enable_o) r_nrd++;
            if (cam_search_enable_o) begin
                r_nsr++;
                if (r_srch_at < 0) r_srch_at = r_lat;
            end
            if (rsp_valid_o) break;
            if (r_lat > 200) begin
                r_lat = -1;
                break;
            end
        end
        r_st = rsp_status_o; r_ix = rsp_index_o; r_dt = rsp_data_o;
        r_stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid_o || req_ready_o || rsp_status_o !== r_st ||
                rsp_index_o !== r_ix || rsp_data_o !== r_dt)
                r_stable = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready_o, rsp_valid_o, cam_read_enable_o, cam_write_enable_o, cam_search_enable_o,
             rsp_status_o, rsp_index_o, rsp_data_o, cam_write_data_o, cam_search_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b valid=%b en=%b%b%b st=%0d idx=%0d data=%h, required all 0",
                     req_ready_o, rsp_valid_o, cam_read_enable_o, cam_write_enable_o,
                     cam_search_enable_o, rsp_status_o, rsp_index_o, rsp_data_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready_o !== 1'b1 || dut.count_q !== 6'd0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b count=%0d, required ready=1 count=0", req_ready_o, dut.count_q);
        end
    endtask

    task automatic test_insert_lookup();
        do_op(OP_INSERT, 32'hDEADBEEF, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_INSERTED || r_ix !== 5'd0 || r_lat != 4 || r_nwr != 1 || dut.count_q !== 6'd1) begin
            n_err++;
            $display("FAIL insert_first: st=%0d idx=%0d lat=%0d wr=%0d count=%0d, required 2/0/4/1/1",
                     r_st, r_ix, r_lat, r_nwr, dut.count_q);
        end
        do_op(OP_LOOKUP, 32'hDEADBEEF, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_HIT || r_ix !== 5'd0 || r_lat != 3 || r_srch_at != 1 || r_nsr != 1) begin
            n_err++;
            $display("FAIL lookup_hit: st=%0d idx=%0d lat=%0d srch_at=%0d srch=%0d, required 0/0/3/1/1",
                     r_st, r_ix, r_lat, r_srch_at, r_nsr);
        end
        do_op(OP_LOOKUP, 32'h12345678, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_MISS || r_ix !== 5'd0 || r_dt !== 32'd0 || r_lat != 3) begin
            n_err++;
            $display("FAIL lookup_miss: st=%0d idx=%0d data=%h lat=%0d, required 1/0/0/3", r_st, r_ix, r_dt, r_lat);
        end
        do_op(OP_INSERT, 32'hDEADBEEF, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_HIT || r_ix !== 5'd0 || r_nwr != 0 || r_lat != 3) begin
            n_err++;
            $display("FAIL insert_dup: st=%0d idx=%0d wr=%0d lat=%0d, required 0/0/0/3", r_st, r_ix, r_nwr, r_lat);
        end
    endtask

    task automatic test_fill();
        do_op(OP_FLUSH, 32'd0, 5'd0, 0);
        for (int i = 0; i < 32; i++) begin
            do_op(OP_INSERT, (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + i, 5'd0, 0);
            n_vec++;
            if (r_st !== ST_INSERTED || r_ix !== 5'(i) || r_nwr != 1) begin
                n_err++;
                $display("FAIL fill_%0d: st=%0d idx=%0d wr=%0d, required 2/%0d/1", i, r_st, r_ix, r_nwr, i);
            end
        end
        do_op(OP_INSERT, 32'h2000_0000, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_FULL || r_ix !== 5'd0 || r_nwr != 0 || dut.count_q !== 6'd32) begin
            n_err++;
            $display("FAIL insert_full: st=%0d idx=%0d wr=%0d count=%0d, required 3/0/0/32",
                     r_st, r_ix, r_nwr, dut.count_q);
        end
    endtask

    task automatic test_flush_stale();
        do_op(OP_FLUSH, 32'd0, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_INSERTED || r_ix !== 5'd0 || r_lat != 1 || dut.count_q !== 6'd0) begin
            n_err++;
            $display("FAIL flush: st=%0d idx=%0d lat=%0d count=%0d, required 2/0/1/0", r_st, r_ix, r_lat, dut.count_q);
        end
        do_op(OP_LOOKUP, 32'hDEADBEEF, 5'd0, 0);
        n_vec++;
        if (r_st !== ST_MISS || cam_search_valid_i !== 1'b1 || cam_search_index_i !== 5'd0) begin
            n_err++;
            $display("FAIL stale_masked: st=%0d cam_valid=%b cam_idx=%0d, required 1/1/0",
                     r_st, cam_search_valid_i, cam_search_index_i);
        end
        do_op(OP_READ, 32'd0, 5'd3, 0);
        n_vec++;
        if (r_st !== ST_MISS || r_dt !== 32'd0 || r_nrd != 0 || r_lat != 2) begin
            n_err++;
            $display("FAIL read_oob: st=%0d data=%h rd=%0d lat=%0d, required 1/0/0/2", r_st, r_dt, r_nrd, r_lat);
        end
    endtask

    task automatic test_read_backpressure();
        do_op(OP_INSERT, 32'hA, 5'd0, 0);
        do_op(OP_INSERT, 32'hB, 5'd0, 0);
        do_op(OP_READ, 32'd0, 5'd1, 5);
        n_vec++;
        if (r_st !== ST_HIT || r_ix !== 5'd1 || r_dt !== 32'hB || r_nrd != 1 || r_lat != 4) begin
            n_err++;
            $display("FAIL read_hit: st=%0d idx=%0d data=%h rd=%0d lat=%0d, required 0/1/b/1/4",
                     r_st, r_ix, r_dt, r_nrd, r_lat);
        end
        n_vec++;
        if (r_stable !== 1'b1) begin
            n_err++;
            $display("FAIL rsp_hold: stable=%b, required 1", r_stable);
        end
    endtask

    task automatic test_abort();
        int  n;
        bit  seen;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = OP_INSERT; req_key_i = 32'h5555AAAA;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            req_valid_i = 1'b0;
            n++;
        end while (!cam_write_enable_o && n < 10);
        n_vec++;
        if (cam_write_enable_o !== 1'b1 || n != 3) begin
            n_err++;
            $display("FAIL abort_write_seen: we=%b cycle=%0d, required 1/3", cam_write_enable_o, n);
        end
        rst_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dut.state_q !== S_IDLE || dut.count_q !== 6'd0 || rsp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: state=%0d count=%0d valid=%b, required 0/0/0",
                     dut.state_q, dut.count_q, rsp_valid_o);
        end
        rst_i = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid_o) seen = 1'b1;
        end
        n_vec++;
        if (seen || req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_no_rsp: rsp_seen=%b ready=%b, required 0/1", seen, req_ready_o);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op, e_st;
        logic [4:0]  idx, e_ix;
        logic [31:0] key, e_dt;
        int          e_lat, r;
        do_op(OP_FLUSH, 32'd0, 5'd0, 0);
        ref_q.delete();
        for (int k = 0; k < 120; k++) begin
            r = int'($urandom_range(0, 19));
            op  = (r < 6) ? OP_LOOKUP : (r < 14) ? OP_INSERT : (r < 19) ? OP_READ : OP_FLUSH;
            key = 32'hC0DE_0000 + $urandom_range(0, 39);
            idx = 5'($urandom_range(0, 31));
            do_op(op, key, idx, int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 3)) : 0);
            model_op(op, key, idx, e_st, e_ix, e_dt, e_lat);
            n_vec++;
            if (r_st !== e_st || r_dt !== e_dt || r_lat != e_lat || r_stable !== 1'b1 ||
                (!(op == OP_READ && e_st == ST_MISS) && r_ix !== e_ix)) begin
                n_err++;
                $display("FAIL rand_%0d op=%0d key=%h idx=%0d: got st=%0d ix=%0d data=%h lat=%0d stable=%b, required st=%0d ix=%0d data=%h lat=%0d",
                         k, op, key, idx, r_st, r_ix, r_dt, r_lat, r_stable, e_st, e_ix, e_dt, e_lat);
            end
            n_vec++;
            if (dut.count_q !== 6'(ref_q.size())) begin
                n_err++;
                $display("FAIL rand_count_%0d: count=%0d, required %0d", k, dut.count_q, ref_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_insert_lookup();
        test_fill();
        test_flush_stale();
        test_read_backpressure();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
